// File: rtl/addr_capture_buf.sv
// Captures one word per cycle at counter-supplied addresses into a DEPTH-entry buffer, then replays it in order over valid/ready.
// Optional write-order checker enabled by defining ADDR_CAPTURE_ORDER_CHK_EN.
module addr_capture_buf #(
    parameter int CNT_WIDTH  = 7,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  wr_en_i,
    input  logic [CNT_WIDTH-1:0]  wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [CNT_WIDTH-1:0]  rd_addr_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  ovf_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    localparam logic [CNT_WIDTH:0]   DEPTH_W   = (CNT_WIDTH + 1)'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] LAST_ADDR = CNT_WIDTH'(DEPTH - 1);

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [CNT_WIDTH-1:0]    rd_ptr_q;
    logic [CNT_WIDTH-1:0]    rd_ptr_d;
    logic                    rd_valid_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic [CNT_WIDTH-1:0]    rd_addr_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    ovf_q;

    logic in_range;
    logic wr_acc;
    logic hs;
    logic last_hs;
    logic load;

    always_comb begin
        in_range = ({1'b0, wr_addr_i} < DEPTH_W);
        wr_acc   = (state_q == FILL) && wr_en_i && in_range;
        hs       = rd_valid_q && rd_ready_i;
        last_hs  = hs && (rd_addr_q == LAST_ADDR);
        // Refill the output register whenever it is empty or being consumed, so a held-high ready streams without bubbles.
        load     = (state_q == DRAIN) && (!rd_valid_q || (hs && !last_hs));
        rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_addr_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= FILL;
                        busy_q  <= 1'b1;
                        ovf_q   <= 1'b0;
                    end
                end
                FILL: begin
                    if (wr_en_i && !in_range) begin
                        ovf_q <= 1'b1;
                    end
                    if (wr_acc && (wr_addr_i == LAST_ADDR)) begin
                        state_q  <= DRAIN;
                        rd_ptr_q <= '0;
                    end
                end
                DRAIN: begin
                    if (last_hs) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        rd_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (load) begin
                rd_data_q  <= mem_q[rd_ptr_q];
                rd_addr_q  <= rd_ptr_q;
                rd_valid_q <= 1'b1;
                rd_ptr_q   <= rd_ptr_d;
            end
        end
    end

`ifdef ADDR_CAPTURE_ORDER_CHK_EN
    logic [CNT_WIDTH-1:0] exp_addr_q;
    logic                 err_q;

    // Expected address starts at 0 for each capture, then follows the last accepted write.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_addr_q <= '0;
            err_q      <= 1'b0;
        end else if ((state_q == IDLE) && start_i) begin
            exp_addr_q <= '0;
            err_q      <= 1'b0;
        end else if (wr_acc) begin
            exp_addr_q <= wr_addr_i + 1'b1;
            if (wr_addr_i != exp_addr_q) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign rd_addr_o  = rd_addr_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign ovf_o      = ovf_q;

endmodule
